// File: rtl/eeg_band_recombiner_if.sv
// Band-sample / gain-programming / result bus of the EEG band recombiner.
// master drives samples and gain writes, slave is the recombiner itself.
interface eeg_band_recombiner_if #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16
);
  logic signed [DATA_W-1:0] band_delta_in;
  logic signed [DATA_W-1:0] band_theta_in;
  logic signed [DATA_W-1:0] band_alpha_in;
  logic signed [DATA_W-1:0] band_beta_in;
  logic                     in_valid;
  logic                     in_ready;
  logic                     gain_wr_en;
  logic [1:0]               gain_wr_sel;
  logic signed [GAIN_W-1:0] gain_wr_data;
  logic signed [DATA_W-1:0] signal_out;
  logic                     out_valid;
  logic                     sat_flag;

  modport master (
    output band_delta_in, band_theta_in, band_alpha_in, band_beta_in,
    output in_valid, gain_wr_en, gain_wr_sel, gain_wr_data,
    input  in_ready, signal_out, out_valid, sat_flag
  );

  modport slave (
    input  band_delta_in, band_theta_in, band_alpha_in, band_beta_in,
    input  in_valid, gain_wr_en, gain_wr_sel, gain_wr_data,
    output in_ready, signal_out, out_valid, sat_flag
  );
endinterface

// File: rtl/eeg_band_recombiner.sv
// Weighted recombination of the four EEG bands with one time-multiplexed MAC:
// each accepted sample set takes four MAC steps plus a round/saturate step.
module eeg_band_recombiner #(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 14,
  parameter int ACC_W     = DATA_W + GAIN_W + 2
) (
  input logic                  clk_slow,
  input logic                  rst,
  eeg_band_recombiner_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAC0 = 3'd1;
  localparam logic [2:0] S_MAC1 = 3'd2;
  localparam logic [2:0] S_MAC2 = 3'd3;
  localparam logic [2:0] S_MAC3 = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam logic signed [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC);
  localparam logic signed [ACC_W-1:0]  ROUND_HALF = ACC_W'(1) << (GAIN_FRAC - 1);
  localparam logic signed [ACC_W-1:0]  SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]               state_q, state_d;
  logic signed [DATA_W-1:0] sample_q [4];
  logic signed [DATA_W-1:0] sample_d [4];
  logic signed [GAIN_W-1:0] gain_q [4];
  logic signed [GAIN_W-1:0] gain_d [4];
  logic signed [GAIN_W-1:0] snap_q [4];
  logic signed [GAIN_W-1:0] snap_d [4];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] signal_out_q, signal_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_q, sat_d;

  logic                     accept;
  logic [1:0]               mac_idx;
  logic signed [DATA_W-1:0] mac_sample;
  logic signed [GAIN_W-1:0] mac_gain;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;

  assign accept = bus.in_valid && (state_q == S_IDLE);

  // MAC0..MAC3 are consecutive codes, so the band index is the offset from MAC0.
  assign mac_idx     = 2'(state_q - S_MAC0);
  assign mac_sample  = sample_q[mac_idx];
  assign mac_gain    = snap_q[mac_idx];
  assign product     = mac_sample * mac_gain;
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign rounded     = acc_q + ROUND_HALF;
  assign shifted     = rounded >>> GAIN_FRAC;

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    gain_d       = gain_q;
    snap_d       = snap_q;
    acc_d        = acc_q;
    signal_out_d = signal_out_q;
    out_valid_d  = 1'b0;
    sat_d        = 1'b0;

    // The snapshot below reads gain_q, so a write on the acceptance edge lands too late for it.
    if (bus.gain_wr_en) gain_d[bus.gain_wr_sel] = bus.gain_wr_data;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sample_d[0] = bus.band_delta_in;
          sample_d[1] = bus.band_theta_in;
          sample_d[2] = bus.band_alpha_in;
          sample_d[3] = bus.band_beta_in;
          snap_d      = gain_q;
          acc_d       = '0;
          state_d     = S_MAC0;
        end
      end
      S_MAC0, S_MAC1, S_MAC2: begin
        acc_d   = acc_q + product_ext;
        state_d = state_q + 3'd1;
      end
      S_MAC3: begin
        acc_d   = acc_q + product_ext;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (shifted > SAT_MAX) begin
          signal_out_d = SAT_MAX[DATA_W-1:0];
          sat_d        = 1'b1;
        end else if (shifted < SAT_MIN) begin
          signal_out_d = SAT_MIN[DATA_W-1:0];
          sat_d        = 1'b1;
        end else begin
          signal_out_d = shifted[DATA_W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_slow) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      signal_out_q <= '0;
      out_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sample_q[i] <= '0;
        gain_q[i]   <= GAIN_UNITY;
        snap_q[i]   <= GAIN_UNITY;
      end
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      signal_out_q <= signal_out_d;
      out_valid_q  <= out_valid_d;
      sat_q        <= sat_d;
      sample_q     <= sample_d;
      gain_q       <= gain_d;
      snap_q       <= snap_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.signal_out = signal_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sat_flag   = sat_q;

endmodule

// File: tb/tb_eeg_band_recombiner.sv
// Self-checking bench for eeg_band_recombiner: randomized sample sets and gains
// compared against an arithmetic model of the weighted, rounded, clipped sum.
module tb_eeg_band_recombiner;

  logic clk_slow = 1'b0;
  logic rst      = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  logic signed [15:0] stim [4];
  logic signed [15:0] model_gain [4];

  eeg_band_recombiner_if #(.DATA_W(16), .GAIN_W(16)) bus ();

  eeg_band_recombiner #(
    .DATA_W(16), .GAIN_W(16), .GAIN_FRAC(14), .ACC_W(34)
  ) dut (
    .clk_slow(clk_slow),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_slow = ~clk_slow;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: sum of sample*gain, add half an LSB, floor-divide by 2^14, clip.
  function automatic void model_calc(output logic signed [15:0] o, output bit sat);
    longint sum, r;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += longint'(stim[i]) * longint'(model_gain[i]);
    r = (sum + 64'sd8192) >>> 14;
    sat = 1'b1;
    if (r > 32767) o = 16'sd32767;
    else if (r < -32768) o = -16'sd32768;
    else begin
      o   = 16'(r);
      sat = 1'b0;
    end
  endfunction

  task automatic apply_stim;
    bus.band_delta_in = stim[0];
    bus.band_theta_in = stim[1];
    bus.band_alpha_in = stim[2];
    bus.band_beta_in  = stim[3];
  endtask

  task automatic write_gain(input logic [1:0] sel, input logic signed [15:0] val);
    bus.gain_wr_en   = 1'b1;
    bus.gain_wr_sel  = sel;
    bus.gain_wr_data = val;
    @(posedge clk_slow); #1;
    bus.gain_wr_en   = 1'b0;
    model_gain[sel]  = val;
  endtask

  task automatic send_set(output logic signed [15:0] o, output logic s, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk_slow); #1;
      guard++;
    end
    apply_stim();
    bus.in_valid = 1'b1;
    @(posedge clk_slow); #1;
    bus.in_valid = 1'b0;
    lat = -1;
    o   = '0;
    s   = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk_slow); #1;
      if (bus.out_valid) begin
        lat = i;
        o   = bus.signal_out;
        s   = bus.sat_flag;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk_slow);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready actual=%b required=1", bus.in_ready); end
    checks++; if (bus.signal_out !== 16'sd0) begin errors++; $display("[TB] FAIL reset_signal_out actual=%0d required=0", bus.signal_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid actual=%b required=0", bus.out_valid); end
    checks++; if (bus.sat_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat_flag actual=%b required=0", bus.sat_flag); end
    rst = 1'b0;
    @(posedge clk_slow); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready actual=%b required=1", bus.in_ready); end
    for (int i = 0; i < 4; i++) model_gain[i] = 16'sd16384;
  endtask

  task automatic test_unity;
    logic signed [15:0] got, exp;
    logic gs;
    bit es;
    int lat;
    stim = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};
    model_calc(exp, es);
    send_set(got, gs, lat);
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL unity_out actual=%0d required=%0d", got, exp); end
    checks++; if (gs !== es) begin errors++; $display("[TB] FAIL unity_sat actual=%b required=%b", gs, es); end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL unity_latency actual=%0d required=5", lat); end
    @(posedge clk_slow); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL out_valid_pulse actual=%b required=0", bus.out_valid); end
    checks++; if (bus.signal_out !== exp) begin errors++; $display("[TB] FAIL out_hold actual=%0d required=%0d", bus.signal_out, exp); end
  endtask

  task automatic test_weighted;
    logic signed [15:0] got, exp;
    logic gs;
    bit es;
    int lat;
    write_gain(2'd0, 16'sd0);
    write_gain(2'd1, 16'sd8192);
    write_gain(2'd2, -16'sd16384);
    write_gain(2'd3, 16'sd16384);
    stim = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
    model_calc(exp, es);
    send_set(got, gs, lat);
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL weighted_out actual=%0d required=%0d", got, exp); end
    checks++; if (gs !== es) begin errors++; $display("[TB] FAIL weighted_sat actual=%b required=%b", gs, es); end
  endtask

  task automatic test_saturation;
    logic signed [15:0] got, exp;
    logic gs;
    bit es;
    int lat;
    for (int i = 0; i < 4; i++) write_gain(2'(i), 16'sd16384);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) stim[i] = (pass == 0) ? 16'sd20000 : -16'sd20000;
      model_calc(exp, es);
      send_set(got, gs, lat);
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL sat_out pass=%0d actual=%0d required=%0d", pass, got, exp); end
      checks++; if (gs !== es) begin errors++; $display("[TB] FAIL sat_flag pass=%0d actual=%b required=%b", pass, gs, es); end
    end
  endtask

  task automatic test_rounding;
    logic signed [15:0] got, exp;
    logic gs;
    bit es;
    int lat;
    write_gain(2'd0, 16'sd8192);
    for (int i = 1; i < 4; i++) write_gain(2'(i), 16'sd0);
    for (int pass = 0; pass < 2; pass++) begin
      stim[0] = (pass == 0) ? 16'sd3 : -16'sd3;
      for (int i = 1; i < 4; i++) stim[i] = 16'($urandom);
      model_calc(exp, es);
      send_set(got, gs, lat);
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL round_out pass=%0d actual=%0d required=%0d", pass, got, exp); end
      checks++; if (gs !== es) begin errors++; $display("[TB] FAIL round_sat pass=%0d actual=%b required=%b", pass, gs, es); end
    end
  endtask

  task automatic test_random;
    logic signed [15:0] got, exp;
    logic gs;
    bit es;
    int lat;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1)
        write_gain(2'($urandom_range(0, 3)), 16'(int'($urandom_range(0, 32767)) - 16384));
      for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
      model_calc(exp, es);
      send_set(got, gs, lat);
      checks++; if (got !== exp) begin errors++; $display("[TB] FAIL random_out n=%0d actual=%0d required=%0d", n, got, exp); end
      checks++; if (gs !== es) begin errors++; $display("[TB] FAIL random_sat n=%0d actual=%b required=%b", n, gs, es); end
      checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL random_latency n=%0d actual=%0d required=5", n, lat); end
    end
  endtask

  // in_valid held high: a new set is taken exactly every sixth edge, and a gain
  // written on an acceptance edge must not reach that set.
  task automatic test_back_to_back;
    int acc_cyc[$];
    logic signed [15:0] exp_o[$];
    bit exp_s[$];
    logic signed [15:0] eo, po;
    bit es, ps;
    int seen;
    bit wr_pending;
    logic [1:0] wr_sel;
    logic signed [15:0] wr_val;
    seen = 0;
    wr_pending = 1'b0;
    wr_sel = 2'd0;
    wr_val = '0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
      apply_stim();
      bus.in_valid = (cyc < 42);
      if (cyc < 42 && bus.in_ready) begin
        model_calc(eo, es);
        exp_o.push_back(eo);
        exp_s.push_back(es);
        acc_cyc.push_back(cyc);
        if (acc_cyc.size() == 2) begin
          wr_sel = 2'($urandom_range(0, 3));
          wr_val = model_gain[wr_sel] ^ 16'sh2A5C;
          bus.gain_wr_en   = 1'b1;
          bus.gain_wr_sel  = wr_sel;
          bus.gain_wr_data = wr_val;
          wr_pending = 1'b1;
        end
      end
      @(posedge clk_slow); #1;
      if (wr_pending) begin
        bus.gain_wr_en = 1'b0;
        model_gain[wr_sel] = wr_val;
        wr_pending = 1'b0;
      end
      if (bus.out_valid) begin
        seen++;
        if (exp_o.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL b2b_unexpected_out cyc=%0d actual=%0d required=none", cyc, bus.signal_out);
        end else begin
          po = exp_o.pop_front();
          ps = exp_s.pop_front();
          checks++; if (bus.signal_out !== po) begin errors++; $display("[TB] FAIL b2b_out cyc=%0d actual=%0d required=%0d", cyc, bus.signal_out, po); end
          checks++; if (bus.sat_flag !== ps) begin errors++; $display("[TB] FAIL b2b_sat cyc=%0d actual=%b required=%b", cyc, bus.sat_flag, ps); end
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (acc_cyc.size() !== 7) begin errors++; $display("[TB] FAIL b2b_accept_count actual=%0d required=7", acc_cyc.size()); end
    checks++; if (seen !== 7) begin errors++; $display("[TB] FAIL b2b_out_count actual=%0d required=7", seen); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
        errors++;
        $display("[TB] FAIL b2b_spacing idx=%0d actual=%0d required=6", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic signed [15:0] got, exp;
    logic gs;
    bit es;
    int lat, seen;
    write_gain(2'd2, -16'sd8192);
    for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
    apply_stim();
    bus.in_valid = 1'b1;
    @(posedge clk_slow); #1;
    bus.in_valid = 1'b0;
    @(posedge clk_slow); #1;
    rst = 1'b1;
    @(posedge clk_slow); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) model_gain[i] = 16'sd16384;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready actual=%b required=1", bus.in_ready); end
    checks++; if (bus.signal_out !== 16'sd0) begin errors++; $display("[TB] FAIL midrst_signal_out actual=%0d required=0", bus.signal_out); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_slow); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midrst_no_out actual=%0d required=0", seen); end
    for (int i = 0; i < 4; i++) stim[i] = 16'(int'($urandom_range(0, 16000)) - 8000);
    model_calc(exp, es);
    send_set(got, gs, lat);
    checks++; if (got !== exp) begin errors++; $display("[TB] FAIL midrst_unity_out actual=%0d required=%0d", got, exp); end
    checks++; if (gs !== es) begin errors++; $display("[TB] FAIL midrst_unity_sat actual=%b required=%b", gs, es); end
  endtask

  initial begin
    bus.band_delta_in = '0;
    bus.band_theta_in = '0;
    bus.band_alpha_in = '0;
    bus.band_beta_in  = '0;
    bus.in_valid      = 1'b0;
    bus.gain_wr_en    = 1'b0;
    bus.gain_wr_sel   = 2'd0;
    bus.gain_wr_data  = '0;
    test_reset();
    test_unity();
    test_weighted();
    test_saturation();
    test_rounding();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
